// File: rtl/serial_monitor_pkg.sv
// Shared types and default constants for the UART receive monitor.
package serial_monitor_pkg;

   // Receiver framing states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_e;

   // 115200 baud at 100 MHz
   localparam int DEF_CLKS_PER_BIT = 868;
   // Receive FIFO entries, power of two
   localparam int DEF_FIFO_DEPTH   = 16;

endpackage : serial_monitor_pkg

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push is refused only when full and not
// popping in the same cycle; a pop is ignored when empty.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | pop);
   assign level   = level_q;
   // Head entry is shown directly; zero while empty so the output is defined after reset
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   // Next pointer and occupancy values
   always_comb begin
      // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; stale entries are never visible because dout is gated by empty.
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule : sync_fifo

// File: rtl/serial_monitor.sv
// UART 8N1 receiver feeding a show-ahead FIFO, with framing-error pulse and
// sticky overflow flag.
module serial_monitor
   import serial_monitor_pkg::*;
#(
   parameter  int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter  int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk100,
   input  logic          sys_rst,
   input  logic          serial_tx,
   output logic [7:0]    m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [LW-1:0] level,
   output logic          frame_err,
   output logic          overflow,
   input  logic          overflow_clr
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          sync1_q, rxs_q;
   state_e        state_q, state_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          frame_err_q, frame_err_d;
   logic          overflow_q, overflow_d;
   logic          push, pop, fifo_empty, fifo_full;

   // Framing decoder: next state, counters and byte assembly from the synchronised line
   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shreg_d     = shreg_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            // Only a falling edge after a seen-high line starts a frame, so a held break is ignored
            if (rxs_q)        armed_d = 1'b1;
            else if (armed_q) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rxs_q ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shreg_d = {rxs_q, shreg_q[7:1]};
               if (idx_q == 3'd7) state_d = ST_STOP;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (rxs_q) begin
                  push = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
                  armed_d     = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Overflow is sticky; a new drop wins over a coincident clear
   always_comb begin
      overflow_d = (push & fifo_full & ~pop) | (overflow_q & ~overflow_clr);
   end

   // Synchroniser, FSM and flag registers
   always_ff @(posedge clk100) begin
      if (sys_rst) begin
         sync1_q     <= 1'b1;
         rxs_q       <= 1'b1;
         state_q     <= ST_IDLE;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         sync1_q     <= serial_tx;
         rxs_q       <= sync1_q;
         state_q     <= state_d;
         armed_q     <= armed_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   assign pop       = m_valid & m_ready;
   assign m_valid   = ~fifo_empty;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk100),
      .rst   (sys_rst),
      .push  (push),
      .pop   (pop),
      .din   (shreg_q),
      .dout  (m_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (level)
   );

endmodule : serial_monitor

// File: doc/serial_monitor.md
SERIAL_MONITOR -- requirements
Module: serial_monitor

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk100 cycles per UART bit (115200 baud at 100 MHz).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the receive FIFO entries (power of two).
REQ-003 The block SHALL have port clk100, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port serial_tx, input, 1 bit: asynchronous UART line from the SoC, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port m_data, output, 8 bits: the byte at the FIFO head.
REQ-007 The block SHALL have port m_valid, output, 1 bit: the FIFO is non-empty.
REQ-008 The block SHALL have port m_ready, input, 1 bit: the consumer accepts m_data.
REQ-009 The block SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: the FIFO occupancy.
REQ-010 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse when a stop bit samples 0.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky, set when a byte is dropped on a full FIFO.
REQ-012 The block SHALL have port overflow_clr, input, 1 bit: clears overflow.

Function
REQ-013 serial_tx SHALL pass through a 2-flop synchroniser; all decoding SHALL use the synchronised value rxs.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP, with a bit-cycle counter and a 3-bit bit index.
REQ-015 IDLE SHALL arm only after rxs has been 1 for at least one cycle, then SHALL go to START on rxs==0 with the counter cleared.
REQ-016 START SHALL sample at counter==CLKS_PER_BIT/2-1: rxs==0 -> DATA with counter 0 and index 0; rxs==1 (glitch) -> IDLE, nothing reported.
REQ-017 DATA SHALL sample rxs at counter==CLKS_PER_BIT-1 into bit[index], LSB first; after index 7 it SHALL go to STOP.
REQ-018 STOP SHALL sample at counter==CLKS_PER_BIT-1: 1 -> push the byte; 0 -> pulse frame_err, discard the byte, and go to IDLE disarmed so a break condition does not retrigger.
REQ-019 The pushed byte SHALL appear on m_data with m_valid=1 on the cycle after the stop-bit sample cycle, if the FIFO was empty.
REQ-020 The FIFO SHALL be show-ahead: m_data is valid whenever m_valid=1, and a pop occurs on m_valid&&m_ready.
REQ-021 A push when full with no pop in the same cycle SHALL drop the byte and set overflow; FIFO contents SHALL be unchanged.
REQ-022 A simultaneous push and pop when full SHALL accept both; level is unchanged and overflow is not set.
REQ-023 A simultaneous push and pop when empty SHALL perform the push only; the pop is ignored since m_valid=0.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH.
REQ-025 If overflow_clr and a new overflow event coincide, overflow SHALL remain set.
REQ-026 m_data SHALL be held stable while m_valid=1 and m_ready=0.

Reset
REQ-027 On sys_rst=1 at a clk100 edge, the FSM SHALL go to IDLE disarmed, counters to 0, FIFO empty, and the synchroniser flops to 1.
REQ-028 Reset values SHALL be m_valid=0, m_data=0, level=0, frame_err=0, overflow=0.
REQ-029 Reset mid-frame SHALL abandon the frame; the remainder of that frame SHALL NOT produce a byte or a frame_err.

Structure
REQ-030 Package serial_monitor_pkg SHALL hold the FSM state enum and the default constants CLKS_PER_BIT=868 and FIFO_DEPTH=16.
REQ-031 The FIFO SHALL be sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, empty, full, level), used by serial_monitor.

Verification
REQ-032 Benches SHALL use CLKS_PER_BIT=16 for runtime.
REQ-033 Scenario: send 0xA5 with m_ready=1 -> exactly one m_valid pulse with m_data=0xA5, frame_err=0.
REQ-034 Scenario: 0 pulse of 4 cycles on an idle line -> no byte and no frame_err; a following 0x3C is received correctly.
REQ-035 Scenario: 0x55 with stop bit driven 0 -> frame_err pulses once, level stays 0; after the line returns high, 0x12 is received.
REQ-036 Scenario: m_ready=0, send 17 bytes 0x00..0x10 -> level=16, overflow=1; reading returns 0x00..0x0F in order; overflow_clr -> overflow=0.
REQ-037 Scenario: FIFO full, m_ready=1 held while byte 0x77 completes -> 0x77 is accepted, level stays 16, overflow=0.
REQ-038 Scenario: sys_rst asserted during data bit 3 of 0xFF -> no output from that frame; the next byte 0x81 is received correctly.
